// File: rtl/module_led_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : module_led_ctrl                                              |
// | Description : Round-robin sequencer that shares the 4-LED display between  |
// |               two requesters. Each granted value is held for HOLD_CYCLES   |
// |               clocks; IDLE_PATTERN is shown when nothing is granted.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module module_led_ctrl #(
  parameter int         HOLD_CYCLES  = 27_000_000,
  parameter logic [3:0] IDLE_PATTERN = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic [3:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [3:0] data_b,
  output logic       ack_b,
  output logic [3:0] led_out,
  output logic       busy,
  output logic       owner
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  // Requester identifiers, shared by owner and the round-robin pointer.
  localparam logic c_src_a = 1'b0;
  localparam logic c_src_b = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_grant;

  logic w_arb_event;
  logic w_grant_a;
  logic w_grant_b;

  // Arbitration happens whenever idle, or on the final cycle of a hold period;
  // on a tie the requester that was not granted last time wins.
  always_comb begin
    w_arb_event = (r_state == ST_IDLE) || (r_cnt == c_cnt_last);
    w_grant_a   = req_a && (!req_b || (r_last_grant == c_src_b));
    w_grant_b   = req_b && (!req_a || (r_last_grant == c_src_a));
  end

  // Display FSM: latch granted data, pulse the ack, and time the hold period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= c_src_b;
      led_out      <= IDLE_PATTERN;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      busy         <= 1'b0;
      owner        <= c_src_a;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      if (w_arb_event) begin
        if (w_grant_a) begin
          r_state      <= ST_SHOW;
          r_cnt        <= '0;
          r_last_grant <= c_src_a;
          led_out      <= data_a;
          ack_a        <= 1'b1;
          busy         <= 1'b1;
          owner        <= c_src_a;
        end else if (w_grant_b) begin
          r_state      <= ST_SHOW;
          r_cnt        <= '0;
          r_last_grant <= c_src_b;
          led_out      <= data_b;
          ack_b        <= 1'b1;
          busy         <= 1'b1;
          owner        <= c_src_b;
        end else begin
          // Nothing pending: fall back to the idle pattern. owner keeps its
          // last value since it is only meaningful while busy.
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          led_out <= IDLE_PATTERN;
          busy    <= 1'b0;
        end
      end else begin
        // Mid-hold: only the counter moves; it cannot pass c_cnt_last because
        // reaching it always triggers arbitration, which reloads it.
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire
